// File: rtl/block_multiplier_2x2_pkg.sv
// block_multiplier_2x2_pkg: shared FSM encoding, float constants and operand index table
package block_multiplier_2x2_pkg;
    localparam int FP_W = 32;
    localparam logic [FP_W-1:0] FP_ZERO = '0;
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_MUL0, S_MUL1, S_ADD, S_DONE
    } state_t;
    // Indexed by {k, phase}; element 0..3 = x11, x12, x21, x22
    localparam logic [7:0][1:0] A_IDX = {2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd0};
    localparam logic [7:0][1:0] B_IDX = {2'd3, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd0};
endpackage

// File: rtl/block_multiplier_2x2_if.sv
// block_multiplier_2x2_if: stb/ack handshake bus to one binary32 arithmetic core
interface block_multiplier_2x2_if;
    import block_multiplier_2x2_pkg::*;
    logic            core_rst;
    logic [FP_W-1:0] input_a, input_b, output_z;
    logic            input_a_stb, input_b_stb, output_z_stb, output_z_ack;
    modport master (
        output core_rst, input_a, input_b, input_a_stb, input_b_stb, output_z_ack,
        input  output_z, output_z_stb
    );
    modport slave (
        input  core_rst, input_a, input_b, input_a_stb, input_b_stb, output_z_ack,
        output output_z, output_z_stb
    );
endinterface

// File: rtl/blkmul_operand_mux.sv
// blkmul_operand_mux: picks the multiplier operands for element k and product phase
module blkmul_operand_mux
    import block_multiplier_2x2_pkg::*;
(
    input  logic [3:0][FP_W-1:0] a,
    input  logic [3:0][FP_W-1:0] b,
    input  logic [1:0]           k,
    input  logic                 ph,
    output logic [FP_W-1:0]      op_a,
    output logic [FP_W-1:0]      op_b
);
    assign op_a = a[A_IDX[{k, ph}]];
    assign op_b = b[B_IDX[{k, ph}]];
endmodule

// File: rtl/block_multiplier_2x2.sv
// block_multiplier_2x2: time-shared 2x2 binary32 block product; BLKMUL_SKIP_ZERO_EN bypasses zero products
module block_multiplier_2x2
    import block_multiplier_2x2_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [FP_W-1:0] i_a11, i_a12, i_a21, i_a22,
    input  logic [FP_W-1:0] i_b11, i_b12, i_b21, i_b22,
    input  logic            start,
    output logic [FP_W-1:0] o_c11, o_c12, o_c21, o_c22,
    output logic            done,
    output logic            busy,
    block_multiplier_2x2_if.master mul_if,
    block_multiplier_2x2_if.master add_if
);
    state_t                state, state_nx;
    logic [1:0]            k;
    logic [3:0][FP_W-1:0]  a_q, b_q, c_w;
    logic [FP_W-1:0]       p0, p1, op_a, op_b, prod, sum;
    logic                  is_mul, mul_skip, add_skip, mul_done, add_done;

    blkmul_operand_mux u_mux (
        .a(a_q), .b(b_q), .k(k), .ph(state == S_MUL1), .op_a(op_a), .op_b(op_b)
    );

`ifdef BLKMUL_SKIP_ZERO_EN
    assign mul_skip = (op_a[FP_W-2:0] == '0) || (op_b[FP_W-2:0] == '0);
    assign add_skip = (p0[FP_W-2:0] == '0) && (p1[FP_W-2:0] == '0);
`else
    assign mul_skip = 1'b0;
    assign add_skip = 1'b0;
`endif

    assign is_mul   = (state == S_MUL0) || (state == S_MUL1);
    assign mul_done = is_mul && (mul_skip || mul_if.output_z_stb);
    assign add_done = (state == S_ADD) && (add_skip || add_if.output_z_stb);
    assign prod     = mul_skip ? FP_ZERO : mul_if.output_z;
    assign sum      = add_skip ? FP_ZERO : add_if.output_z;
    assign busy     = state != S_IDLE;

    // Core handshakes: strobes held for the whole op, ack only in the result cycle
    always_comb begin
        mul_if.core_rst     = (state == S_IDLE) || (state == S_DONE);
        mul_if.input_a      = op_a;
        mul_if.input_b      = op_b;
        mul_if.input_a_stb  = is_mul && !mul_skip;
        mul_if.input_b_stb  = is_mul && !mul_skip;
        mul_if.output_z_ack = is_mul && !mul_skip && mul_if.output_z_stb;
        add_if.core_rst     = (state == S_IDLE) || (state == S_DONE);
        add_if.input_a      = p0;
        add_if.input_b      = p1;
        add_if.input_a_stb  = (state == S_ADD) && !add_skip;
        add_if.input_b_stb  = (state == S_ADD) && !add_skip;
        add_if.output_z_ack = (state == S_ADD) && !add_skip && add_if.output_z_stb;
    end

    // Sequencing: two products then one sum per element, four elements per job
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = start ? S_SETUP : S_IDLE;
            S_SETUP: state_nx = S_MUL0;
            S_MUL0:  state_nx = mul_done ? S_MUL1 : S_MUL0;
            S_MUL1:  state_nx = mul_done ? S_ADD : S_MUL1;
            S_ADD:   state_nx = add_done ? ((k == 2'd3) ? S_DONE : S_MUL0) : S_ADD;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Datapath: operand latch, product/sum capture, result publish with done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q  <= '0;
            b_q  <= '0;
            c_w  <= '0;
            p0   <= '0;
            p1   <= '0;
            k    <= '0;
            done <= 1'b0;
            {o_c22, o_c21, o_c12, o_c11} <= '0;
        end else begin
            done <= state == S_DONE;
            if (state == S_IDLE && start) begin
                a_q <= {i_a22, i_a21, i_a12, i_a11};
                b_q <= {i_b22, i_b21, i_b12, i_b11};
                k   <= '0;
            end
            if (state == S_MUL0 && mul_done) p0 <= prod;
            if (state == S_MUL1 && mul_done) p1 <= prod;
            if (add_done) begin
                c_w[k] <= sum;
                k      <= k + 1'b1;
            end
            if (state == S_DONE) {o_c22, o_c21, o_c12, o_c11} <= c_w;
        end
    end
endmodule
